// File: rtl/main_pkg.sv
// Shared definitions for the bus-based programmer block: module select codes,
// the per-module control latch layout, and datapath widths.
// Build option: define MAIN_SUB_EN to let the ALU subtract when its SUB bit is set.
package main_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 4;
  localparam int RAM_DEPTH   = 1 << ADDR_W;

  // Module select codes; also used as indices into the control latch array.
  localparam int MOD_PC      = 0;
  localparam int MOD_A       = 1;
  localparam int MOD_B       = 2;
  localparam int MOD_ALU     = 3;
  localparam int MOD_MAR     = 4;
  localparam int MOD_RAM     = 5;
  localparam int MOD_OUT     = 6;
  localparam int NUM_MODULES = 7;

  // Control latch owned by every module, field order matches {en, OE, WE, load, SUB}.
  typedef struct packed {
    logic en;
    logic oe;
    logic we;
    logic load;
    logic sub;
  } ctrl_t;

  // Codes 7..15 are reserved and must not touch any latch.
  function automatic logic sel_valid(input logic [3:0] sel);
    return sel < 4'(NUM_MODULES);
  endfunction

endpackage

// File: rtl/main_reg8.sv
// 8-bit register used for A, B and OUT: loads from the programmer data input
// (load has priority) or from the shared bus (WE), cleared asynchronously.
// Build option: none (MAIN_SUB_EN only affects the ALU in main).
module main_reg8
  import main_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              we_i,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] q_o,
  output logic              oe_o
);

  logic [DATA_W-1:0] q_d, q_q;

  // Next value: programmer data beats bus data when both writes are enabled.
  always_comb begin
    // NOTE: default assignment first so every path assigns q_d and no latch is inferred.
    q_d = q_q;
    if (load_i) begin
      q_d = in_i;
    end else if (we_i) begin
      q_d = bus_i;
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign oe_o = oe_i;

endmodule

// File: rtl/main.sv
// Bus-based programmer block: a 4-bit program counter, A/B registers, an
// adder/subtractor, MAR, 16x8 RAM and an OUT register share one 8-bit bus.
// Each module owns a control latch written by a strobe; datapath writes use
// the latch values from before the edge.
// Build option: define MAIN_SUB_EN to make the ALU honour its latched SUB bit.
module main
  import main_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] in,
  input  logic              go,
  input  logic              en,
  input  logic              OE,
  input  logic              WE,
  input  logic              load,
  input  logic              SUB,
  input  logic              HLT,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] Bus_out,
  output logic              on
);

  // ---------------------------------------------------------------------------
  // Reset: asserts immediately, releases two CLK edges after RESET rises.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Deassertion synchroniser shifting ones in behind an asynchronous clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Control latches
  // ---------------------------------------------------------------------------
  ctrl_t                   ctrl_in;
  ctrl_t [NUM_MODULES-1:0] ctrl_d, ctrl_q;

  assign ctrl_in = '{en: en, oe: OE, we: WE, load: load, sub: SUB};

  // Strobe writes the selected module's latch; reserved codes leave all alone.
  always_comb begin
    ctrl_d = ctrl_q;
    if (go && sel_valid(sel)) begin
      ctrl_d[sel[2:0]] = ctrl_in;
    end
  end

  // Latch storage, cleared by reset so no module drives or writes afterwards.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Several modules have no use for some latch bits (e.g. en outside the PC).
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_q;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] count_d, count_q;
  logic [ADDR_W-1:0] mar_d, mar_q;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic              a_oe, b_oe, out_oe;
  logic [DATA_W-1:0] alu_val;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic [DATA_W-1:0] bus;

  main_reg8 u_a (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .load_i (ctrl_q[MOD_A].load),
    .we_i   (ctrl_q[MOD_A].we),
    .oe_i   (ctrl_q[MOD_A].oe),
    .in_i   (in),
    .bus_i  (bus),
    .q_o    (a_q),
    .oe_o   (a_oe)
  );

  main_reg8 u_b (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .load_i (ctrl_q[MOD_B].load),
    .we_i   (ctrl_q[MOD_B].we),
    .oe_i   (ctrl_q[MOD_B].oe),
    .in_i   (in),
    .bus_i  (bus),
    .q_o    (b_q),
    .oe_o   (b_oe)
  );

  main_reg8 u_out (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .load_i (ctrl_q[MOD_OUT].load),
    .we_i   (ctrl_q[MOD_OUT].we),
    .oe_i   (ctrl_q[MOD_OUT].oe),
    .in_i   (in),
    .bus_i  (bus),
    .q_o    (out_q),
    .oe_o   (out_oe)
  );

  // ALU result; without the build option the SUB latch bit is ignored.
  always_comb begin
`ifdef MAIN_SUB_EN
    alu_val = ctrl_q[MOD_ALU].sub ? (a_q - b_q) : (a_q + b_q);
`else
    alu_val = a_q + b_q;
`endif
  end

  assign ram_rd = ram_q[mar_q];

  // Bus: lowest-coded module with latched OE wins, otherwise the bus idles at zero.
  // MAR places its address on the low nibble when asked to drive.
  always_comb begin
    bus = '0;
    if (ctrl_q[MOD_PC].oe) begin
      bus = {{(DATA_W-ADDR_W){1'b0}}, count_q};
    end else if (a_oe) begin
      bus = a_q;
    end else if (b_oe) begin
      bus = b_q;
    end else if (ctrl_q[MOD_ALU].oe) begin
      bus = alu_val;
    end else if (ctrl_q[MOD_MAR].oe) begin
      bus = {{(DATA_W-ADDR_W){1'b0}}, mar_q};
    end else if (ctrl_q[MOD_RAM].oe) begin
      bus = ram_rd;
    end else if (out_oe) begin
      bus = out_q;
    end
  end

  // PC next value: load, then bus write, then increment unless halted.
  always_comb begin
    count_d = count_q;
    if (ctrl_q[MOD_PC].load) begin
      count_d = in[ADDR_W-1:0];
    end else if (ctrl_q[MOD_PC].we) begin
      count_d = bus[ADDR_W-1:0];
    end else if (ctrl_q[MOD_PC].en && !HLT) begin
      count_d = count_q + 1'b1;
    end
  end

  // MAR next value: low nibble of programmer data or bus.
  always_comb begin
    mar_d = mar_q;
    if (ctrl_q[MOD_MAR].load) begin
      mar_d = in[ADDR_W-1:0];
    end else if (ctrl_q[MOD_MAR].we) begin
      mar_d = bus[ADDR_W-1:0];
    end
  end

  // PC and MAR registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mar_q   <= '0;
    end else begin
      count_q <= count_d;
      mar_q   <= mar_d;
    end
  end

  // RAM write port at the current MAR address.
  always_ff @(posedge CLK) begin
    // NOTE: the RAM array has no reset; its contents survive RESET by design.
    if (ctrl_q[MOD_RAM].load) begin
      ram_q[mar_q] <= in;
    end else if (ctrl_q[MOD_RAM].we) begin
      ram_q[mar_q] <= bus;
    end
  end

  assign count   = count_q;
  assign Bus_out = bus;
  assign on      = ctrl_q[MOD_PC].en & ~HLT & ~ctrl_q[MOD_PC].load;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for main: reset checks, a directed vector table,
// hand-written RAM/bus/halt/reset sequences and randomized traffic compared
// against a behavioural model of the module set.
module tb_main;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] sel;
  logic [7:0] in;
  logic       go, en, OE, WE, load, SUB, HLT;
  logic [3:0] count;
  logic [7:0] Bus_out;
  logic       on;

  main dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .sel     (sel),
    .in      (in),
    .go      (go),
    .en      (en),
    .OE      (OE),
    .WE      (WE),
    .load    (load),
    .SUB     (SUB),
    .HLT     (HLT),
    .count   (count),
    .Bus_out (Bus_out),
    .on      (on)
  );

  always #5 CLK = ~CLK;

  // Control word bit positions in {en, OE, WE, load, SUB}.
  localparam int EN_B = 4, OE_B = 3, WE_B = 2, LD_B = 1, SUB_B = 0;

`ifdef MAIN_SUB_EN
  localparam logic [7:0] ALU73 = 8'h04;  // 7 - 3
  localparam logic [7:0] ALU37 = 8'hFC;  // 3 - 7 mod 256
`else
  localparam logic [7:0] ALU73 = 8'h0A;  // 7 + 3
  localparam logic [7:0] ALU37 = 8'h0A;  // 3 + 7
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: seven modules, their control words, and a RAM array.
  // ---------------------------------------------------------------------------
  logic [4:0] m_ctrl [7];
  logic [3:0] m_cnt, m_mar;
  logic [7:0] m_a, m_b, m_out;
  logic [7:0] m_ram [16];
  int         m_sync;

  function automatic logic [7:0] model_val(input int i);
    int r;
    case (i)
      0: return {4'h0, m_cnt};
      1: return m_a;
      2: return m_b;
      3: begin
        r = int'(m_a) + int'(m_b);
`ifdef MAIN_SUB_EN
        if (m_ctrl[3][SUB_B]) r = int'(m_a) - int'(m_b);
`endif
        if (r < 0) r += 256;
        return 8'(r % 256);
      end
      4: return {4'h0, m_mar};
      5: return m_ram[m_mar];
      default: return m_out;
    endcase
  endfunction

  function automatic logic [7:0] model_bus();
    for (int i = 0; i < 7; i++)
      if (m_ctrl[i][OE_B]) return model_val(i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] next8(input logic [4:0] c, input logic [7:0] cur,
                                       input logic [7:0] d, input logic [7:0] b);
    if (c[LD_B]) return d;
    if (c[WE_B]) return b;
    return cur;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 7; i++) m_ctrl[i] = 5'b0;
    m_cnt = 0; m_mar = 0; m_a = 0; m_b = 0; m_out = 0; m_sync = 0;
  endtask

  task automatic model_edge(input logic [3:0] s, input logic [7:0] d, input logic g,
                            input logic [4:0] c, input logic h);
    logic [7:0] b;
    logic [3:0] old_mar;
    if (m_sync >= 2) begin
      b       = model_bus();
      old_mar = m_mar;
      if (m_ctrl[0][LD_B])                m_cnt = d[3:0];
      else if (m_ctrl[0][WE_B])           m_cnt = b[3:0];
      else if (m_ctrl[0][EN_B] && !h)     m_cnt = 4'((int'(m_cnt) + 1) % 16);
      m_a   = next8(m_ctrl[1], m_a, d, b);
      m_b   = next8(m_ctrl[2], m_b, d, b);
      m_out = next8(m_ctrl[6], m_out, d, b);
      if (m_ctrl[4][LD_B])      m_mar = d[3:0];
      else if (m_ctrl[4][WE_B]) m_mar = b[3:0];
      if (m_ctrl[5][LD_B])      m_ram[old_mar] = d;
      else if (m_ctrl[5][WE_B]) m_ram[old_mar] = b;
      if (g && int'(s) < 7) m_ctrl[int'(s)] = c;
    end
    if (!RESET) m_sync = 0;
    else if (m_sync < 2) m_sync++;
  endtask

  // One clock: drive inputs after a falling edge, update model at the rising
  // edge, return at the next falling edge for sampling.
  task automatic tick(input logic [3:0] s, input logic [7:0] d, input logic g,
                      input logic [4:0] c, input logic h);
    sel = s; in = d; go = g; {en, OE, WE, load, SUB} = c; HLT = h;
    @(posedge CLK);
    model_edge(s, d, g, c, h);
    @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, count, m_cnt);
    check({tag, "_bus"}, Bus_out, model_bus());
    check({tag, "_on"}, on, m_ctrl[0][EN_B] && !HLT && !m_ctrl[0][LD_B]);
  endtask

  task automatic tk(input logic [3:0] s, input logic [7:0] d, input logic g,
                    input logic [4:0] c, input logic h, input string tag);
    tick(s, d, g, c, h);
    check_model(tag);
  endtask

  // Assert RESET between edges and confirm the immediate clear.
  task automatic async_reset(input string tag);
    #2 RESET = 1'b0;
    model_clear();
    #1;
    check({tag, "_count"}, count, 4'h0);
    check({tag, "_bus"}, Bus_out, 8'h00);
    check({tag, "_on"}, on, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] s;
    logic [7:0] d;
    logic       g;
    logic [4:0] c;
    logic       h;
    logic [3:0] e_cnt;
    logic [7:0] e_bus;
    logic       e_on;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] s, input logic [7:0] d, input logic g,
                              input logic [4:0] c, input logic h, input logic [3:0] ec,
                              input logic [7:0] eb, input logic eo);
    vec_t v;
    v.s = s; v.d = d; v.g = g; v.c = c; v.h = h;
    v.e_cnt = ec; v.e_bus = eb; v.e_on = eo;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(4'd0, 8'h00, 1, 5'b11000, 0, 4'h0, 8'h00, 1));  // start PC, drive bus
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 0, 4'h1, 8'h01, 1));
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 0, 4'h2, 8'h02, 1));
    vecs.push_back(mk(4'd1, 8'h07, 1, 5'b00010, 0, 4'h3, 8'h03, 1));  // A load
    vecs.push_back(mk(4'd1, 8'h07, 1, 5'b00000, 0, 4'h4, 8'h04, 1));  // A = 07
    vecs.push_back(mk(4'd2, 8'h03, 1, 5'b00010, 0, 4'h5, 8'h05, 1));  // B load
    vecs.push_back(mk(4'd2, 8'h03, 1, 5'b00000, 0, 4'h6, 8'h06, 1));  // B = 03
    vecs.push_back(mk(4'd3, 8'h00, 1, 5'b01001, 0, 4'h7, 8'h07, 1));  // ALU OE loses to PC
    vecs.push_back(mk(4'd0, 8'h00, 1, 5'b00000, 0, 4'h8, ALU73, 0));  // PC stops, ALU drives
    vecs.push_back(mk(4'd0, 8'hA5, 1, 5'b00010, 0, 4'h8, ALU73, 0));  // PC load captured
    vecs.push_back(mk(4'd0, 8'hA5, 0, 5'b00000, 0, 4'h5, ALU73, 0));  // count <= 5
    vecs.push_back(mk(4'd0, 8'hA5, 1, 5'b11000, 0, 4'h5, 8'h05, 1));  // still loading, then run
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 0, 4'h6, 8'h06, 1));
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 1, 4'h6, 8'h06, 0));  // halt x3
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 1, 4'h6, 8'h06, 0));
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 1, 4'h6, 8'h06, 0));
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 0, 4'h7, 8'h07, 1));  // resume
    vecs.push_back(mk(4'd0, 8'h0F, 1, 5'b01010, 0, 4'h8, 8'h08, 0));  // load F
    vecs.push_back(mk(4'd0, 8'h0F, 1, 5'b11000, 0, 4'hF, 8'h0F, 1));
    vecs.push_back(mk(4'd0, 8'h00, 0, 5'b00000, 0, 4'h0, 8'h00, 1));  // wrap F -> 0
    vecs.push_back(mk(4'd7, 8'hFF, 1, 5'b11111, 0, 4'h1, 8'h01, 1));  // reserved code
    vecs.push_back(mk(4'd15, 8'h00, 1, 5'b00000, 0, 4'h2, 8'h02, 1)); // reserved code
    vecs.push_back(mk(4'd1, 8'h03, 1, 5'b00010, 0, 4'h3, 8'h03, 1));  // A load
    vecs.push_back(mk(4'd1, 8'h03, 1, 5'b00000, 0, 4'h4, 8'h04, 1));  // A = 03
    vecs.push_back(mk(4'd2, 8'h07, 1, 5'b00010, 0, 4'h5, 8'h05, 1));  // B load
    vecs.push_back(mk(4'd2, 8'h07, 1, 5'b00000, 0, 4'h6, 8'h06, 1));  // B = 07
    vecs.push_back(mk(4'd0, 8'h00, 1, 5'b00000, 0, 4'h7, ALU37, 0));  // ALU drives 3 op 7

    RESET = 1'b0; sel = 0; in = 0; go = 0; {en, OE, WE, load, SUB} = 5'b0; HLT = 0;
    model_clear();
    @(negedge CLK);
    check("reset_count", count, 4'h0);
    check("reset_bus", Bus_out, 8'h00);
    check("reset_on", on, 1'b0);

    // Strobes during reset and during the synchroniser release must be ignored.
    tick(4'd0, 8'h00, 1, 5'b11000, 0);
    tick(4'd0, 8'h00, 1, 5'b11000, 0);
    RESET = 1'b1;
    tick(4'd0, 8'h00, 1, 5'b11000, 0);
    tick(4'd0, 8'h00, 1, 5'b11000, 0);
    check("sync_count", count, 4'h0);
    check("sync_bus", Bus_out, 8'h00);
    check("sync_on", on, 1'b0);

    foreach (vecs[i]) begin
      tick(vecs[i].s, vecs[i].d, vecs[i].g, vecs[i].c, vecs[i].h);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      check($sformatf("vec%0d_bus", i), Bus_out, vecs[i].e_bus);
      check($sformatf("vec%0d_on", i), on, vecs[i].e_on);
    end

    // RAM via MAR, OUT from bus, bus priority.
    tk(4'd3, 8'h00, 1, 5'b00000, 0, "alu_off");
    check("idle_bus", Bus_out, 8'h00);
    tk(4'd4, 8'h02, 1, 5'b00010, 0, "mar_ld");
    tk(4'd4, 8'h02, 1, 5'b00000, 0, "mar_2");
    tk(4'd5, 8'h5A, 1, 5'b00010, 0, "ram_ld");
    tk(4'd5, 8'h5A, 1, 5'b01000, 0, "ram_wr");
    check("ram_oe_bus", Bus_out, 8'h5A);
    tk(4'd6, 8'h00, 1, 5'b00100, 0, "out_we");
    tk(4'd6, 8'h00, 1, 5'b00000, 0, "out_cap");
    tk(4'd5, 8'h00, 1, 5'b00000, 0, "ram_off");
    tk(4'd6, 8'h00, 1, 5'b01000, 0, "out_oe");
    check("out_oe_bus", Bus_out, 8'h5A);
    tk(4'd5, 8'h00, 1, 5'b01000, 0, "ram_out_oe");
    tk(4'd0, 8'h00, 1, 5'b01000, 0, "pc_ram_oe");
    check("pc_beats_ram", Bus_out, 8'h07);

    // PC load still works while halted.
    tk(4'd0, 8'h0C, 1, 5'b00010, 1, "hlt_ld");
    tk(4'd0, 8'h0C, 1, 5'b01000, 1, "hlt_ld2");
    check("load_under_hlt", count, 4'hC);

    // Reset in the middle of counting; RAM survives.
    tk(4'd0, 8'h00, 1, 5'b11000, 0, "run");
    tk(4'd0, 8'h00, 0, 5'b00000, 0, "run1");
    tk(4'd0, 8'h00, 0, 5'b00000, 0, "run2");
    async_reset("midreset");
    tk(4'd0, 8'h00, 0, 5'b00000, 0, "rel1");
    tk(4'd0, 8'h00, 0, 5'b00000, 0, "rel2");
    tk(4'd4, 8'h02, 1, 5'b00010, 0, "mar_ld_b");
    tk(4'd4, 8'h02, 1, 5'b00000, 0, "mar_2_b");
    tk(4'd5, 8'h00, 1, 5'b01000, 0, "ram_rd_b");
    check("ram_kept", Bus_out, 8'h5A);

    // Give every RAM word a known value before random traffic.
    for (int i = 0; i < 7; i++) tick(4'(i), 8'h00, 1, 5'b00000, 0);
    for (int a = 0; a < 16; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      tick(4'd4, 8'(a), 1, 5'b00010, 0);
      tick(4'd4, 8'(a), 1, 5'b00000, 0);
      tick(4'd5, v, 1, 5'b00010, 0);
      tick(4'd5, v, 1, 5'b00000, 0);
    end
    check_model("ram_init");

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] s;
      logic       g, h;
      s = 4'($urandom_range(0, 15));
      g = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 7) == 0);
      tk(s, 8'($urandom), g, 5'($urandom), h, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 199) == 0) async_reset($sformatf("rndrst%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
